counter_scan_mux: RTL and testbench
===================================

Name: counter_scan_mux

Overview:
- Parametrised successor to the scope's 16:1 counter selector.
- Selects one of NCH W-bit counter values. Two modes:
  - Manual: registered mux driven by a select input.
  - Scan: snapshots all channels on a start pulse, then streams them out one per valid/ready handshake with channel tag and last flag.
- Sits between the per-channel trigger/edge counters and the display/UART readout path.

Parameters:
- NCH, 16, number of counter channels (2..64).
- W, 8, width of each counter value.
- REVERSE, 1, 1: select index s maps to channel NCH-1-s (legacy scope ordering); 0: s maps to channel s.
- SELW (localparam), clog2(NCH), width of select and channel-tag fields.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- count_flat  in  NCH*W  packed counter inputs; channel c occupies bits [c*W +: W].
- mode  in  1  0 = manual, 1 = scan.
- mux_sel  in  SELW  manual-mode select index.
- start  in  1  one-cycle pulse; begins a scan in scan mode.
- out_data  out  W  selected or streamed value.
- out_chan  out  SELW  select index belonging to out_data.
- out_valid  out  1  scan-mode beat valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the final beat (index NCH-1).
- busy  out  1  high while a scan is in progress.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-low.
  - Reset (rst_n=0 at a clk edge) forces state IDLE, and sets out_data=0, out_chan=0, out_valid=0, out_last=0, busy=0, and the internal index and snapshot bank to 0.
  - Reset mid-scan aborts immediately; no further beats are produced.
- Mapping: index s selects channel (REVERSE ? NCH-1-s : s). If s >= NCH (possible only when NCH is not a power of 2), out_data=0.
- States: IDLE, SCAN.
- IDLE, mode=0 (manual):
  - Each cycle: out_data <= mapped channel of mux_sel; out_chan <= mux_sel. Latency is 1 cycle.
  - out_valid=0, out_last=0, busy=0.
- IDLE, mode=1 without start: out_data and out_chan hold their last values; out_valid=0.
- IDLE, mode=1 and start=1:
  - All NCH channels are captured into the snapshot bank on that edge.
  - Index is set to 0; next state is SCAN.
  - From the next cycle: busy=1, out_valid=1, out_chan=0, out_data=snapshot(mapped 0).
- SCAN:
  - out_data and out_chan hold stable while out_valid=1 and out_ready=0 (AXI-style: no retraction).
  - On out_valid & out_ready:
    - If index < NCH-1: index increments, and the next beat is presented the following cycle. Back-to-back beats are allowed, so the scan takes NCH cycles with out_ready tied high.
    - If index = NCH-1 (out_last=1): next state is IDLE, with out_valid=0, out_last=0, busy=0 in the next cycle.
  - out_last = out_valid & (index == NCH-1).
- Ignored inputs during SCAN:
  - start is ignored; no restart and no re-snapshot.
  - mode and mux_sel changes are ignored until return to IDLE.
  - count_flat changes do not affect streamed data; the snapshot is coherent.
- start with mode=0 is ignored.
- Start in the same cycle as the final accept: IDLE is entered first; that start is ignored. A new start is required in IDLE.
- No arithmetic; index counter width SELW, no wrap (terminates at NCH-1).

Decomposition:
- Shared package/header:
  - State encodings (IDLE=0, SCAN=1).
  - MODE_MANUAL/MODE_SCAN constants.
  - A clog2 function used for SELW.
- One natural sub-module, counter_snapshot_bank: NCH×W register bank with capture enable and an indexed combinational read port applying the REVERSE mapping. The top module holds the FSM, index counter and output registers.

Test Plan (NCH=16, W=8, REVERSE=1, channel c driven with 8'h10+c unless stated):
- Reset: hold rst_n=0 for 3 cycles with mode=1 and start pulsed -> all outputs 0, busy=0 throughout.
- Manual: mode=0, mux_sel=15 -> out_data=8'h10 one cycle later. mux_sel=0 -> 8'h1F. With REVERSE=0, mux_sel=3 -> 8'h13.
- Scan with out_ready=1:
  - Pulse start -> 16 consecutive beats: out_chan 0..15, out_data 8'h1F down to 8'h10.
  - out_last only on beat 15; busy falls the cycle after.
- Backpressure and coherence:
  - Toggle out_ready randomly and change all count_flat to 8'hAA after start -> beats still carry the snapshot 8'h1F..8'h10.
  - Data and tag stay stable while stalled; no beat is dropped or duplicated.
- Ignored controls:
  - start pulsed at beat 5 and mode=0 at beat 8 -> scan continues unchanged to beat 15.
  - start coincident with final accept -> no new scan.
- Mid-scan reset: assert rst_n=0 at beat 7 -> next cycle out_valid=0, busy=0. A subsequent start restarts at out_chan=0.

Source files
------------

// File: rtl/counter_scan_mux_pkg.sv
// Shared types and constants for the counter selector / scan streamer.
package counter_scan_mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/counter_snapshot_bank.sv
// NCH x W capture bank with a combinational read port that applies the select-to-channel mapping.
module counter_snapshot_bank
   import counter_scan_mux_pkg::*;
#(
   parameter int NCH     = 16,
   parameter int W       = 8,
   parameter int REVERSE = 1,
   parameter int SELW    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                capture,
   input  logic [NCH*W-1:0]    count_flat,
   input  logic [SELW-1:0]     rd_idx,
   output logic [W-1:0]        rd_data
);

   localparam logic [SELW-1:0] LAST_IDX = SELW'(NCH - 1);

   logic [W-1:0]    bank [NCH];
   logic [SELW-1:0] phys;
   logic            in_range;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) bank[c] <= '0;
      end else if (capture) begin
         for (int c = 0; c < NCH; c++) bank[c] <= count_flat[c*W +: W];
      end
   end

   // Indices past the last channel only exist when NCH is not a power of two; they read as zero.
   assign in_range = ({1'b0, rd_idx} < (SELW+1)'(NCH));
   assign phys     = (REVERSE != 0) ? (LAST_IDX - rd_idx) : rd_idx;

   always_comb begin
      rd_data = '0;
      if (in_range) rd_data = bank[phys];
   end

endmodule

// File: rtl/counter_scan_mux.sv
// Counter selector: registered manual mux, or a coherent snapshot streamed out over valid/ready.
module counter_scan_mux
   import counter_scan_mux_pkg::*;
#(
   parameter int  NCH     = 16,
   parameter int  W       = 8,
   parameter int  REVERSE = 1,
   localparam int SELW    = clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH*W-1:0]    count_flat,
   input  logic                mode,
   input  logic [SELW-1:0]     mux_sel,
   input  logic                start,
   output logic [W-1:0]        out_data,
   output logic [SELW-1:0]     out_chan,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy
);

   localparam logic [SELW-1:0] LAST_IDX = SELW'(NCH - 1);
   localparam int              FIRST_CH = (REVERSE != 0) ? NCH - 1 : 0;

   state_t          state;
   logic [SELW-1:0] idx;
   logic [SELW-1:0] nxt_idx;
   logic [W-1:0]    snap_rd;
   logic [W-1:0]    live_rd;
   logic [W-1:0]    live [NCH];
   logic [SELW-1:0] live_phys;
   logic            capture;

   for (genvar c = 0; c < NCH; c++) begin : g_unpack
      assign live[c] = count_flat[c*W +: W];
   end

   assign live_phys = (REVERSE != 0) ? (LAST_IDX - mux_sel) : mux_sel;

   always_comb begin
      live_rd = '0;
      if ({1'b0, mux_sel} < (SELW+1)'(NCH)) live_rd = live[live_phys];
   end

   assign capture = (state == IDLE) && (mode == MODE_SCAN) && start;
   assign nxt_idx = idx + 1'b1;

   // The bank is read one index ahead so the next beat can be loaded on the accepting edge.
   counter_snapshot_bank #(
      .NCH     (NCH),
      .W       (W),
      .REVERSE (REVERSE),
      .SELW    (SELW)
   ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture    (capture),
      .count_flat (count_flat),
      .rd_idx     (nxt_idx),
      .rd_data    (snap_rd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
               if (mode == MODE_MANUAL) begin
                  out_data <= live_rd;
                  out_chan <= mux_sel;
               end else if (start) begin
                  // First beat comes straight from the inputs, identical to what the bank captures now.
                  state     <= SCAN;
                  idx       <= '0;
                  out_data  <= live[FIRST_CH];
                  out_chan  <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            SCAN: begin
               if (out_valid && out_ready) begin
                  if (idx == LAST_IDX) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     idx      <= nxt_idx;
                     out_chan <= nxt_idx;
                     out_data <= snap_rd;
                     out_last <= (nxt_idx == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_scan_mux.sv
// Bench for counter_scan_mux: manual vector table, random manual mode, and scan sequences vs a snapshot model.
module tb_counter_scan_mux;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] flat;
   logic         mode;
   logic [3:0]   mux_sel;
   logic         start;
   logic         out_ready;

   logic [7:0]   out_data, fwd_data, sm_data;
   logic [3:0]   out_chan, fwd_chan;
   logic [2:0]   sm_chan;
   logic         out_valid, out_last, busy;
   logic         fwd_valid, fwd_last, fwd_busy;
   logic         sm_valid, sm_last, sm_busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   counter_scan_mux #(.NCH(16), .W(8), .REVERSE(1)) dut (
      .clk(clk), .rst_n(rst_n), .count_flat(flat), .mode(mode), .mux_sel(mux_sel),
      .start(start), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy));

   counter_scan_mux #(.NCH(16), .W(8), .REVERSE(0)) dut_fwd (
      .clk(clk), .rst_n(rst_n), .count_flat(flat), .mode(mode), .mux_sel(mux_sel),
      .start(start), .out_data(fwd_data), .out_chan(fwd_chan), .out_valid(fwd_valid),
      .out_ready(out_ready), .out_last(fwd_last), .busy(fwd_busy));

   counter_scan_mux #(.NCH(5), .W(8), .REVERSE(1)) dut_small (
      .clk(clk), .rst_n(rst_n), .count_flat(flat[39:0]), .mode(mode), .mux_sel(mux_sel[2:0]),
      .start(start), .out_data(sm_data), .out_chan(sm_chan), .out_valid(sm_valid),
      .out_ready(out_ready), .out_last(sm_last), .busy(sm_busy));

   // Reference: value shown for select s of an nch-channel bank.
   function automatic logic [7:0] ref_val(input logic [127:0] f, input int nch, input int rev, input int s);
      int ch;
      if (s >= nch) return 8'h00;
      ch = (rev != 0) ? (nch - 1 - s) : s;
      return 8'(f >> (ch * 8));
   endfunction

   function automatic logic [127:0] default_flat();
      logic [127:0] f;
      for (int c = 0; c < 16; c++) f[c*8 +: 8] = 8'(8'h10 + c);
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] sel;
      logic [7:0] exp_rev;
      logic [7:0] exp_fwd;
      logic [7:0] exp_small;
   } man_vec_t;

   // Streams one scan; optionally asserts reset when beat reset_at is on the outputs.
   task automatic run_scan(input int ready_pct, input int reset_at);
      logic [127:0] snap;
      int exp_b;
      int cycles;
      bit acc;
      snap = flat;
      mode = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      flat = {16{8'hAA}};
      exp_b = 0;
      cycles = 0;
      while (exp_b < 16 && cycles < 400) begin
         out_ready = ($urandom_range(0, 99) < ready_pct);
         check("scan_valid", out_valid, 1'b1);
         check("scan_busy", busy, 1'b1);
         check("scan_chan", out_chan, exp_b);
         check("scan_data", out_data, ref_val(snap, 16, 1, exp_b));
         check("scan_last", out_last, (exp_b == 15));
         if (exp_b == reset_at) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            check("abort_valid", out_valid, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_data", out_data, 8'h00);
            return;
         end
         acc = out_ready;
         step();
         cycles++;
         if (acc) exp_b++;
      end
      if (exp_b < 16) check("scan_timeout", exp_b, 16);
      check("scan_end_valid", out_valid, 1'b0);
      check("scan_end_busy", busy, 1'b0);
      check("scan_end_last", out_last, 1'b0);
   endtask

   initial begin
      man_vec_t vecs[6];
      logic [7:0] r;

      rst_n = 1'b0;
      flat = default_flat();
      mode = 1'b1;
      mux_sel = 4'd0;
      start = 1'b1;
      out_ready = 1'b1;

      for (int i = 0; i < 3; i++) begin
         step();
         start = (i == 0);
         check("rst_data", out_data, 8'h00);
         check("rst_chan", out_chan, 4'd0);
         check("rst_valid", out_valid, 1'b0);
         check("rst_last", out_last, 1'b0);
         check("rst_busy", busy, 1'b0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      step();
      check("idle_hold_valid", out_valid, 1'b0);
      check("idle_hold_data", out_data, 8'h00);

      vecs[0] = '{4'd15, 8'h10, 8'h1F, 8'h00};
      vecs[1] = '{4'd0,  8'h1F, 8'h10, 8'h14};
      vecs[2] = '{4'd3,  8'h1C, 8'h13, 8'h11};
      vecs[3] = '{4'd4,  8'h1B, 8'h14, 8'h10};
      vecs[4] = '{4'd5,  8'h1A, 8'h15, 8'h00};
      vecs[5] = '{4'd9,  8'h16, 8'h19, 8'h13};
      mode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mux_sel = vecs[i].sel;
         start = 1'b1;
         step();
         start = 1'b0;
         check("man_rev", out_data, vecs[i].exp_rev);
         check("man_fwd", fwd_data, vecs[i].exp_fwd);
         check("man_small", sm_data, vecs[i].exp_small);
         check("man_chan", out_chan, vecs[i].sel);
         check("man_valid", out_valid, 1'b0);
         check("man_busy", busy, 1'b0);
      end

      for (int i = 0; i < 20; i++) begin
         flat = {$urandom, $urandom, $urandom, $urandom};
         mux_sel = 4'($urandom_range(0, 15));
         step();
         r = ref_val(flat, 16, 1, int'(mux_sel));
         check("rman_rev", out_data, r);
         check("rman_fwd", fwd_data, ref_val(flat, 16, 0, int'(mux_sel)));
         check("rman_small", sm_data, ref_val(flat, 5, 1, int'(mux_sel[2:0])));
      end

      // Full-rate scan with stray controls, ending with a start coincident with the final accept.
      flat = default_flat();
      out_ready = 1'b1;
      mode = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int b = 0; b < 16; b++) begin
         check("fr_valid", out_valid, 1'b1);
         check("fr_busy", busy, 1'b1);
         check("fr_chan", out_chan, b);
         check("fr_data", out_data, 8'(8'h1F - b));
         check("fr_last", out_last, (b == 15));
         start = (b == 5) || (b == 15);
         if (b == 8) mode = 1'b0;
         if (b == 12) mode = 1'b1;
         if (b == 10) flat = {16{8'h55}};
         step();
      end
      start = 1'b0;
      check("fr_end_valid", out_valid, 1'b0);
      check("fr_end_busy", busy, 1'b0);
      check("fr_end_last", out_last, 1'b0);
      step();
      check("no_restart_valid", out_valid, 1'b0);
      check("no_restart_busy", busy, 1'b0);
      check("idle_hold_data2", out_data, 8'h10);
      check("idle_hold_chan2", out_chan, 4'd15);

      flat = default_flat();
      run_scan(50, -1);
      flat = {$urandom, $urandom, $urandom, $urandom};
      run_scan(30, -1);

      flat = default_flat();
      run_scan(100, 7);
      step();
      check("post_abort_valid", out_valid, 1'b0);
      flat = default_flat();
      run_scan(70, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
